// File: rtl/matmul_output_collector_if.sv
// ---------------------------------------------------------------------------
// matmul_output_collector_if
//   Output-memory write port used by the matmul output collector.
//   The collector presents one packed result row per request and holds it
//   until the memory acknowledges it.
//
//   mem_wr_req  master->slave  write request (row valid)
//   mem_wr_ack  slave->master  row accepted this cycle
//   mem_addr    master->slave  32-bit row address
//   mem_data    master->slave  COLS*WORD_SIZE packed row, column 0 in the LSBs
// ---------------------------------------------------------------------------
interface matmul_output_collector_if #(
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16
);
  logic                      mem_wr_req;
  logic                      mem_wr_ack;
  logic [31:0]               mem_addr;
  logic [COLS*WORD_SIZE-1:0] mem_data;

  modport master (output mem_wr_req, output mem_addr, output mem_data, input  mem_wr_ack);
  modport slave  (input  mem_wr_req, input  mem_addr, input  mem_data, output mem_wr_ack);
endinterface

// File: rtl/matmul_output_collector.sv
// ---------------------------------------------------------------------------
// matmul_output_collector
//   Collects held, staggered per-column results from the systolic array or
//   the proxy (repair) path, accumulates them over K-tile passes, then writes
//   the ROWS x COLS result matrix to memory one row per request/ack.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     stall             freezes capture and hold counters
//     fsm_done          all passes complete; start write-out (ACCUM only)
//     sa_valid/sa_data  per-column array results (column c at [c*W +: W])
//     proxy_valid/data  per-column proxy results, same packing
//     proxy_sel         1 = column sourced from proxy path
//     mem               write port (matmul_output_collector_if.master)
//     wr_output_rdy     high while results may be accepted
//     wr_output_done    one-cycle pulse after the last row is accepted
//     incomplete        sticky: a column was mid-pass at fsm_done
//     overflow          sticky: an element was clamped at write-out
//
//   Build option: define OUTCTRL_SATURATE_EN to clamp each element to the
//   signed WORD_SIZE range at write-out (and flag overflow). Without it the
//   low WORD_SIZE bits are written and overflow stays 0.
// ---------------------------------------------------------------------------
module matmul_output_collector #(
  parameter int          ROWS        = 4,
  parameter int          COLS        = 4,
  parameter int          WORD_SIZE   = 16,
  parameter int          ACC_WIDTH   = 32,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] ADDR_INCR   = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      fsm_done,
  input  logic [COLS-1:0]           sa_valid,
  input  logic [COLS*WORD_SIZE-1:0] sa_data,
  input  logic [COLS-1:0]           proxy_valid,
  input  logic [COLS*WORD_SIZE-1:0] proxy_data,
  input  logic [COLS-1:0]           proxy_sel,
  matmul_output_collector_if.master mem,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic                      incomplete,
  output logic                      overflow
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

`ifdef OUTCTRL_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (WORD_SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;
  logic [COLS-1:0] clip;
`endif

  logic [1:0]               state_q;
  logic [RW-1:0]            row_idx_q;
  logic                     incomplete_q;
  logic                     overflow_q;
  logic [COLS-1:0]          row_pending;
  logic [COLS*WORD_SIZE-1:0] row_data;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [HW-1:0]                hold_cnt_q;
      logic [RW-1:0]                row_cnt_q;
      logic [RW-1:0]                row_cnt_d;
      logic signed [ACC_WIDTH-1:0]  acc_q [ROWS];
      logic                         src_valid;
      logic signed [WORD_SIZE-1:0]  src_data;
      logic                         capture;

      assign src_valid = proxy_sel[gi] ? proxy_valid[gi] : sa_valid[gi];
      assign src_data  = proxy_sel[gi] ? proxy_data[gi*WORD_SIZE +: WORD_SIZE]
                                       : sa_data[gi*WORD_SIZE +: WORD_SIZE];
      // Only the first cycle of each held result is captured.
      assign capture   = (state_q == ST_ACCUM) && src_valid && !stall && (hold_cnt_q == '0);

      always_comb begin
        row_cnt_d = row_cnt_q;
        if (capture) begin
          row_cnt_d = (row_cnt_q == RW'(ROWS - 1)) ? '0 : row_cnt_q + RW'(1);
        end
      end

      // Uses the post-capture count so a pass finishing in the fsm_done
      // cycle is not flagged as incomplete.
      assign row_pending[gi] = (row_cnt_d != '0);

      always_ff @(posedge clk) begin
        if (rst || state_q == ST_CLEAR) begin
          hold_cnt_q <= '0;
          row_cnt_q  <= '0;
          for (int r = 0; r < ROWS; r++) begin
            acc_q[r] <= '0;
          end
        end else if (state_q == ST_ACCUM) begin
          if (!src_valid) begin
            hold_cnt_q <= '0;
          end else if (!stall) begin
            hold_cnt_q <= (hold_cnt_q == HW'(HOLD_CYCLES - 1)) ? '0 : hold_cnt_q + HW'(1);
          end
          if (capture) begin
            // Size cast of a signed operand sign-extends; the sum wraps.
            acc_q[row_cnt_q] <= acc_q[row_cnt_q] + ACC_WIDTH'(src_data);
          end
          row_cnt_q <= row_cnt_d;
        end
      end

`ifdef OUTCTRL_SATURATE_EN
      logic signed [ACC_WIDTH-1:0] rd_acc;
      assign rd_acc   = acc_q[row_idx_q];
      assign clip[gi] = (rd_acc > SAT_MAX) || (rd_acc < SAT_MIN);
      assign row_data[gi*WORD_SIZE +: WORD_SIZE] =
          (rd_acc > SAT_MAX) ? SAT_MAX[WORD_SIZE-1:0] :
          (rd_acc < SAT_MIN) ? SAT_MIN[WORD_SIZE-1:0] : rd_acc[WORD_SIZE-1:0];
`else
      assign row_data[gi*WORD_SIZE +: WORD_SIZE] = acc_q[row_idx_q][WORD_SIZE-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      row_idx_q    <= '0;
      incomplete_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (fsm_done) begin
            state_q   <= ST_WRITE;
            row_idx_q <= '0;
            if (|row_pending) incomplete_q <= 1'b1;
          end
        end
        ST_WRITE: begin
`ifdef OUTCTRL_SATURATE_EN
          if (|clip) overflow_q <= 1'b1;
`endif
          if (mem.mem_wr_ack) begin
            if (row_idx_q == RW'(ROWS - 1)) begin
              state_q <= ST_CLEAR;
            end else begin
              row_idx_q <= row_idx_q + RW'(1);
            end
          end
        end
        ST_CLEAR: state_q <= ST_ACCUM;
        default:  state_q <= ST_ACCUM;
      endcase
    end
  end

  assign mem.mem_wr_req = (state_q == ST_WRITE);
  assign mem.mem_addr   = (state_q == ST_WRITE) ? BASE_ADDR + 32'(row_idx_q) * ADDR_INCR : '0;
  assign mem.mem_data   = (state_q == ST_WRITE) ? row_data : '0;

  // Ready comes back together with the done pulse, i.e. during the clear
  // cycle, so upstream may restart without waiting an extra cycle.
  assign wr_output_rdy  = (state_q != ST_WRITE);
  assign wr_output_done = (state_q == ST_CLEAR);
  assign incomplete     = incomplete_q;
`ifdef OUTCTRL_SATURATE_EN
  assign overflow       = overflow_q;
`else
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_output_collector.sv
module tb_matmul_output_collector;
  localparam int          ROWS = 4;
  localparam int          COLS = 4;
  localparam int          W    = 16;
  localparam int          HOLD = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] INCR = 32'd4;
  localparam int          SMAX = (1 << (W - 1)) - 1;
  localparam int          SMIN = -(1 << (W - 1));

  logic                clk = 1'b0;
  logic                rst, stall, fsm_done;
  logic [COLS-1:0]     sa_valid, proxy_valid, proxy_sel;
  logic [COLS*W-1:0]   sa_data, proxy_data;
  logic                wr_output_rdy, wr_output_done, incomplete, overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: matrix of sums plus per-column pass position.
  int  m_acc [ROWS][COLS];
  int  m_row [COLS];
  bit  m_incomplete, m_overflow;
  int  sa_vals [ROWS][COLS];
  int  px_vals [ROWS][COLS];

  matmul_output_collector_if #(.COLS(COLS), .WORD_SIZE(W)) mem_if ();

  matmul_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .ACC_WIDTH(32), .HOLD_CYCLES(HOLD),
    .BASE_ADDR(BASE), .ADDR_INCR(INCR)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .fsm_done(fsm_done),
    .sa_valid(sa_valid), .sa_data(sa_data),
    .proxy_valid(proxy_valid), .proxy_data(proxy_data), .proxy_sel(proxy_sel),
    .mem(mem_if.master),
    .wr_output_rdy(wr_output_rdy), .wr_output_done(wr_output_done),
    .incomplete(incomplete), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit stickies);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_acc[r][c] = 0;
    for (int c = 0; c < COLS; c++) m_row[c] = 0;
    if (stickies) begin
      m_incomplete = 0;
      m_overflow   = 0;
    end
  endtask

  // Expected row as written to memory, and whether any element clamps.
  task automatic exp_row(input int r, output logic [63:0] d, output bit clipped);
    d = '0;
    clipped = 0;
    for (int c = 0; c < COLS; c++) begin
      int a;
      a = m_acc[r][c];
`ifdef OUTCTRL_SATURATE_EN
      if (a > SMAX) begin a = SMAX; clipped = 1; end
      else if (a < SMIN) begin a = SMIN; clipped = 1; end
`endif
      d[c*W +: W] = W'(a);
    end
  endtask

  // One pass: each enabled column sends nrows values, each held HOLD
  // cycles back-to-back, column c starting c cycles late. Optional stall
  // window freezes the schedule for stall_len cycles at step stall_step.
  task automatic drive_pass(input logic [COLS-1:0] sel, input logic [COLS-1:0] mask,
                            input int nrows, input int stall_step, input int stall_len);
    int t = 0;
    int stalled = 0;
    int total = COLS - 1 + nrows * HOLD;
    proxy_sel = sel;
    while (t < total) begin
      stall = (t == stall_step && stalled < stall_len);
      if (stall) stalled++;
      for (int c = 0; c < COLS; c++) begin
        int k;
        bit v;
        k = t - c;
        v = mask[c] && k >= 0 && k < nrows * HOLD;
        sa_valid[c]    = v;
        proxy_valid[c] = v;
        sa_data[c*W +: W]    = v ? W'(sa_vals[k / HOLD][c]) : '0;
        proxy_data[c*W +: W] = v ? W'(px_vals[k / HOLD][c]) : '0;
      end
      @(negedge clk);
      if (!stall) t++;
    end
    stall = 0;
    sa_valid = '0;
    proxy_valid = '0;
    sa_data = '0;
    proxy_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if (mask[c]) begin
        for (int r = 0; r < nrows; r++) begin
          logic signed [W-1:0] v;
          v = sel[c] ? W'(px_vals[r][c]) : W'(sa_vals[r][c]);
          m_acc[m_row[c]][c] += int'(v);
          m_row[c] = (m_row[c] + 1) % ROWS;
        end
      end
    end
    $display("[TB] pass sel=%b mask=%b rows=%0d stall@%0d x%0d", sel, mask, nrows, stall_step, stall_len);
  endtask

  task automatic writeout(input string name, input int delay_row, input int delay);
    logic [63:0] d;
    bit clipped;
    for (int c = 0; c < COLS; c++) if (m_row[c] != 0) m_incomplete = 1;
    fsm_done = 1;
    @(negedge clk);
    fsm_done = 0;
    for (int r = 0; r < ROWS; r++) begin
      exp_row(r, d, clipped);
      if (clipped) m_overflow = 1;
      mem_if.mem_wr_ack = 0;
      for (int i = 0; i < ((r == delay_row) ? delay : 0); i++) begin
        check($sformatf("%s_hold_req_r%0d_%0d", name, r, i), 64'(mem_if.mem_wr_req), 64'd1);
        check($sformatf("%s_hold_addr_r%0d_%0d", name, r, i), 64'(mem_if.mem_addr), 64'(BASE + r * INCR));
        check($sformatf("%s_hold_data_r%0d_%0d", name, r, i), 64'(mem_if.mem_data), d);
        @(negedge clk);
      end
      check($sformatf("%s_req_r%0d", name, r), 64'(mem_if.mem_wr_req), 64'd1);
      check($sformatf("%s_rdy_r%0d", name, r), 64'(wr_output_rdy), 64'd0);
      check($sformatf("%s_addr_r%0d", name, r), 64'(mem_if.mem_addr), 64'(BASE + r * INCR));
      check($sformatf("%s_data_r%0d", name, r), 64'(mem_if.mem_data), d);
      $display("[TB] %s write row %0d addr %08h data %016h", name, r, mem_if.mem_addr, mem_if.mem_data);
      mem_if.mem_wr_ack = 1;
      @(negedge clk);
      mem_if.mem_wr_ack = 0;
    end
    check({name, "_req_low"}, 64'(mem_if.mem_wr_req), 64'd0);
    check({name, "_done"}, 64'(wr_output_done), 64'd1);
    check({name, "_rdy"}, 64'(wr_output_rdy), 64'd1);
    check({name, "_incomplete"}, 64'(incomplete), 64'(m_incomplete));
    check({name, "_overflow"}, 64'(overflow), 64'(m_overflow));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(wr_output_done), 64'd0);
    model_clear(0);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sa_vals[r][c] = int'($urandom_range(hi - lo)) + lo;
        px_vals[r][c] = int'($urandom_range(hi - lo)) + lo;
      end
  endtask

  initial begin
    rst = 1; stall = 0; fsm_done = 0;
    sa_valid = '0; proxy_valid = '0; proxy_sel = '0;
    sa_data = '0; proxy_data = '0;
    mem_if.mem_wr_ack = 0;
    model_clear(1);
    repeat (3) @(negedge clk);
    rst = 0;

    // Reset state
    check("rst_req", 64'(mem_if.mem_wr_req), 64'd0);
    check("rst_addr", 64'(mem_if.mem_addr), 64'd0);
    check("rst_data", 64'(mem_if.mem_data), 64'd0);
    check("rst_rdy", 64'(wr_output_rdy), 64'd1);
    check("rst_done", 64'(wr_output_done), 64'd0);
    check("rst_incomplete", 64'(incomplete), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Single pass of 10r+c
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sa_vals[r][c] = 10 * r + c;
        px_vals[r][c] = 0;
      end
    drive_pass('0, '1, ROWS, -1, 0);
    writeout("single", -1, 0);

    // Two K-tile passes of 3s
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) sa_vals[r][c] = 3;
    drive_pass('0, '1, ROWS, -1, 0);
    drive_pass('0, '1, ROWS, -1, 0);
    writeout("two_pass", -1, 0);

    // Proxy substitution on column 2
    fill_random(-1000, 1000);
    for (int r = 0; r < ROWS; r++) begin
      sa_vals[r][2] = 999;
      px_vals[r][2] = 7;
    end
    drive_pass(4'b0100, '1, ROWS, -1, 0);
    writeout("proxy", -1, 0);

    // Stall for 3 cycles mid-hold
    fill_random(-2000, 2000);
    drive_pass('0, '1, ROWS, 3, 3);
    fill_random(-2000, 2000);
    drive_pass(4'b1001, '1, ROWS, 6, 3);
    writeout("stall", -1, 0);

    // Ack withheld 5 cycles on row 1
    fill_random(-5000, 5000);
    drive_pass('0, '1, ROWS, -1, 0);
    writeout("ack_wait", 1, 5);

    // 4 passes of 20000 -> 80000 per element (clamp or truncate)
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) sa_vals[r][c] = 20000;
    repeat (4) drive_pass('0, '1, ROWS, -1, 0);
    writeout("big", -1, 0);

    // Three captures on one column then fsm_done -> incomplete
    fill_random(-100, 100);
    drive_pass('0, 4'b0001, 3, -1, 0);
    writeout("partial", -1, 0);

    // Reset during write-out
    fill_random(-100, 100);
    drive_pass('0, '1, ROWS, -1, 0);
    fsm_done = 1;
    @(negedge clk);
    fsm_done = 0;
    check("midrst_req_before", 64'(mem_if.mem_wr_req), 64'd1);
    rst = 1;
    @(negedge clk);
    check("midrst_req", 64'(mem_if.mem_wr_req), 64'd0);
    check("midrst_rdy", 64'(wr_output_rdy), 64'd1);
    check("midrst_incomplete", 64'(incomplete), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    rst = 0;
    model_clear(1);
    @(negedge clk);
    $display("[TB] reset during write-out");

    // Fresh pass after reset must start from empty accumulators
    fill_random(-300, 300);
    drive_pass('0, '1, ROWS, -1, 0);
    writeout("after_rst", -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
